// File: rtl/not_16.sv
// rtl/not_16.sv - bitwise inverter with optional registered output and valid flag
//
// Ports:
//   clk     - rising-edge clock for the registered path
//   rst_n   - asynchronous active-low reset; clears out_q and out_vld
//   in      - operand to invert (WIDTH bits)
//   en      - load enable for the registered path
//   out     - ~in directly (REG_OUT=0) or a copy of out_q (REG_OUT=1)
//   out_q   - registered ~in, loaded on a clk edge with en=1
//   out_vld - set once out_q has been loaded since the last reset

module not_16 #(
    parameter int WIDTH   = 16,
    parameter bit REG_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             out_vld
);

    // Pure per-bit complement; each bit of inv depends only on the same bit of in.
    logic [WIDTH-1:0] inv;
    assign inv = ~in;

    // Registered copy. The asynchronous clear means a reset between edges
    // drops the held value immediately rather than at the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            out_vld <= 1'b0;
        end else if (en) begin
            out_q   <= inv;
            out_vld <= 1'b1;
        end
    end

    // Output routing is fixed at elaboration; the combinational path carries
    // no clock or reset dependence.
    generate
        if (REG_OUT) begin : g_reg_out
            assign out = out_q;
        end else begin : g_comb_out
            assign out = inv;
        end
    endgenerate

endmodule

// File: tb/tb_not_16.sv
// tb/tb_not_16.sv - scoreboard bench for not_16, combinational and registered builds

module tb_not_16;

    logic        clk;
    logic        clk_run;
    logic        rst_n;
    logic        en;
    logic [15:0] in_v;

    logic [15:0] out0, outq0;
    logic        vld0;
    logic [15:0] out1, outq1;
    logic        vld1;

    not_16 #(.WIDTH(16), .REG_OUT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in(in_v), .en(en),
        .out(out0), .out_q(outq0), .out_vld(vld0)
    );

    not_16 #(.WIDTH(16), .REG_OUT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in(in_v), .en(en),
        .out(out1), .out_q(outq1), .out_vld(vld1)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // sel: 0 comb out, 1 reg out_q, 2 reg out_vld, 3 reg out
    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   req_cnt  = 0;
    int   checks   = 0;
    int   failures = 0;

    task automatic expect_val(input string name, input int sel, input logic [15:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        exp_q.push_back(e);
    endtask

    task automatic trigger();
        req_cnt++;
        #1;
    endtask

    task automatic expect_reg(input string name, input logic [15:0] q, input logic v);
        expect_val({name, "_q"}, 1, q);
        expect_val({name, "_vld"}, 2, {15'b0, v});
        expect_val({name, "_out"}, 3, q);
        trigger();
    endtask

    // Monitor: drains the scoreboard each time stimulus announces a sample point.
    initial begin
        forever begin
            @(req_cnt);
            while (exp_q.size() > 0) begin
                exp_t        e;
                logic [15:0] act;
                e = exp_q.pop_front();
                case (e.sel)
                    0:       act = out0;
                    1:       act = outq1;
                    2:       act = {15'b0, vld1};
                    default: act = out1;
                endcase
                checks++;
                if (act !== e.exp) begin
                    failures++;
                    $display("FAIL %s actual=%h expected=%h", e.name, act, e.exp);
                end
            end
        end
    end

    logic [15:0] vec_in  [5] = '{16'h0000, 16'hFFFF, 16'hAAAA, 16'h3CC3, 16'h1234};
    logic [15:0] vec_exp [5] = '{16'hFFFF, 16'h0000, 16'h5555, 16'hC33C, 16'hEDCB};

    initial begin
        clk_run = 1'b0;
        rst_n   = 1'b0;
        en      = 1'b0;
        in_v    = 16'h0000;
        #3;

        // Reset with no clock running; comb path still tracks ~in.
        expect_reg("reset_noclk", 16'h0000, 1'b0);
        expect_val("comb_in_reset", 0, 16'hFFFF);
        trigger();

        // Directed combinational vectors.
        for (int i = 0; i < 5; i++) begin
            in_v = vec_in[i];
            #1;
            expect_val($sformatf("comb_%h", vec_in[i]), 0, vec_exp[i]);
            trigger();
        end

        // en is ignored while reset is held, even with edges.
        clk_run = 1'b1;
        en      = 1'b1;
        in_v    = 16'h1234;
        @(negedge clk);
        @(negedge clk);
        expect_reg("en_in_reset", 16'h0000, 1'b0);

        // Release reset; first enabled edge loads.
        rst_n = 1'b1;
        @(negedge clk);
        expect_reg("first_load", 16'hEDCB, 1'b1);

        // Hold for three edges with en=0.
        en   = 1'b0;
        in_v = 16'hAAAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            expect_reg($sformatf("hold_%0d", i), 16'hEDCB, 1'b1);
        end

        // Load 5555 then assert reset between edges.
        en = 1'b1;
        @(negedge clk);
        expect_reg("load_5555", 16'h5555, 1'b1);
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        expect_reg("async_reset", 16'h0000, 1'b0);

        // Release with en=0: nothing loads until en rises.
        @(negedge clk);
        rst_n = 1'b1;
        in_v  = 16'h3CC3;
        @(negedge clk);
        expect_reg("release_no_en", 16'h0000, 1'b0);
        en = 1'b1;
        @(negedge clk);
        expect_reg("load_c33c", 16'hC33C, 1'b1);
        en = 1'b0;

        // Exhaustive combinational sweep.
        for (int i = 0; i < 65536; i++) begin
            logic [15:0] v;
            v    = 16'(i);
            in_v = v;
            #1;
            expect_val($sformatf("sweep_%h", v), 0, ~v);
            trigger();
        end

        // Registered value must be untouched by the sweep with en=0.
        expect_reg("post_sweep", 16'hC33C, 1'b1);

        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/not_16.md
NOT_16 -- requirements
Module: not_16

Interface
REQ-001 Parameter WIDTH, default 16, data width in bits; all data ports and registers SHALL use WIDTH.
REQ-002 Parameter REG_OUT, default 0, selects which path drives out: 0 = combinational, 1 = registered copy.
REQ-003 Port clk, input, 1 bit; the single clock, rising-edge active.
REQ-004 Port rst_n, input, 1 bit; the reset is asynchronous and active-low.
REQ-005 Port in, input, WIDTH bits; the operand to invert.
REQ-006 Port en, input, 1 bit; load enable for the registered path.
REQ-007 Port out, output, WIDTH bits; the bitwise complement of in, routed per REQ-002.
REQ-008 Port out_q, output, WIDTH bits; registered complement of in.
REQ-009 Port out_vld, output, 1 bit; high when out_q holds a value loaded since the last reset.

Function
REQ-010 With REG_OUT=0, out SHALL equal ~in bit-for-bit, combinationally, with zero clock latency.
- No clock or reset dependence on this path.
- out SHALL settle within the same simulation time step as the change on in.
REQ-011 Each bit i of out SHALL depend only on bit i of in; no bit reordering, carry or sign handling.
REQ-012 On a rising clk edge with en=1, out_q SHALL load ~in and out_vld SHALL be set to 1.
REQ-013 On a rising clk edge with en=0, out_q and out_vld SHALL hold their values.
REQ-014 Registered path latency SHALL be exactly one clk cycle from the sampled in to out_q.
REQ-015 With REG_OUT=1, out SHALL equal out_q.
REQ-016 If in changes on the same edge at which it is sampled, out_q SHALL take the value present at setup time; there is no bypass.
REQ-017 The block SHALL contain no other state and no X-propagation beyond X inputs (X in -> X out per bit).

Reset
REQ-018 rst_n=0 SHALL, immediately and independent of clk, force out_q to all-zeros and out_vld to 0.
REQ-019 While rst_n=0, en SHALL be ignored and the combinational out (REG_OUT=0) SHALL keep tracking ~in.
REQ-020 Reset release SHALL be clean at the next rising clk edge: the first load occurs at the first edge with rst_n=1 and en=1.
REQ-021 Reset asserted mid-operation SHALL discard the held out_q value; out_vld returns to 0.

Verification
REQ-022 REG_OUT=0, in=16'h0000 -> out=16'hFFFF after one time unit; in=16'hFFFF -> out=16'h0000.
REQ-023 REG_OUT=0, in=16'hAAAA -> out=16'h5555; in=16'h3CC3 -> out=16'hC33C; in=16'h1234 -> out=16'hEDCB.
REQ-024 Registered path:
- rst_n=0 -> out_q=16'h0000 and out_vld=0 with no clock running.
- Release rst_n, en=1, in=16'h1234, one edge -> out_q=16'hEDCB, out_vld=1.
REQ-025 Hold behaviour: out_q=16'hEDCB, en=0, in=16'hAAAA for 3 edges -> out_q stays 16'hEDCB.
REQ-026 Async reset mid-operation: out_q=16'h5555, assert rst_n=0 between edges -> out_q=16'h0000 and out_vld=0 at once.
REQ-027 Exhaustive sweep: all 65536 in values with REG_OUT=0 -> out==~in for every value, zero mismatches.
